// File: rtl/instr_encoder_pkg.sv
// Shared types for the instruction encoder: request classes, RV32 opcodes,
// FSM states and the request legality check used when INSTR_ENC_CHECK_EN is defined.
package instr_pkg;

  typedef enum logic [2:0] {
    CLS_ALUI   = 3'd0,
    CLS_BRANCH = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_JAL    = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_LUI    = 3'd6
  } instr_class_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2
  } state_e;

  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // An immediate fits a signed N-bit field when every bit above N-1 copies bit N-1.
  function automatic logic is_legal(input logic [2:0] cls, input logic [2:0] f3,
                                    input logic [31:0] imm);
    logic fits12;
    logic fits13;
    logic fits21;
    logic shamt_ok;
    logic ok;
    fits12   = (imm[31:11] == {21{imm[11]}});
    fits13   = (imm[31:12] == {20{imm[12]}});
    fits21   = (imm[31:20] == {12{imm[20]}});
    shamt_ok = (imm[31:5] == 27'd0);
    case (cls)
      CLS_ALUI:   ok = (f3 == 3'b000) ? fits12 : ((f3 == 3'b001) ? shamt_ok : 1'b0);
      CLS_BRANCH: ok = ((f3 == 3'b000) || (f3 == 3'b001)) && fits13 && !imm[0];
      CLS_LOAD,
      CLS_STORE:  ok = (f3 == 3'b010) && fits12;
      CLS_JALR:   ok = (f3 == 3'b000) && fits12;
      CLS_JAL:    ok = fits21 && !imm[0];
      CLS_LUI:    ok = (imm[11:0] == 12'd0);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32 format packer: class plus raw fields in, 32-bit instruction word out.
module instr_pack
  import instr_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  // Branch and jump immediates are byte offsets, so bit 0 is never encoded.
  always_comb begin
    word = NOP_WORD;
    case (cls)
      CLS_ALUI: begin
        if (funct3 == 3'b001)
          word = {7'b0000000, imm[4:0], rs1, funct3, rd, OP_ALUI};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_ALUI};
      end
      CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      CLS_JALR:   word = {imm[11:0], rs1, funct3, rd, OP_JALR};
      CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      CLS_LUI:    word = {imm[31:12], rd, OP_LUI};
      default:    word = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one encode request, packs it and writes it to sequential
// instruction-memory addresses. Define INSTR_ENC_CHECK_EN to reject illegal requests via err.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_class,
  input  logic [2:0]               req_funct3,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rs1,
  input  logic [4:0]               req_rs2,
  input  logic [31:0]              req_imm,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  output logic [15:0]              count,
  output logic                     err
);

  state_e      state;
  logic [2:0]  cls_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [31:0] imm_q;
  logic [31:0] packed_word;
  logic        enc_ok;

  instr_pack u_pack (
    .cls    (cls_q),
    .funct3 (f3_q),
    .rd     (rd_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .imm    (imm_q),
    .word   (packed_word)
  );

`ifdef INSTR_ENC_CHECK_EN
  assign enc_ok = is_legal(cls_q, f3_q, imm_q);
`else
  assign enc_ok = 1'b1;
`endif

  assign req_ready = (state == S_IDLE);

  // Clear is applied after the FSM so it overrides a same-edge address increment,
  // while the write itself still completes normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_addr  <= BASE_ADDR;
      count     <= '0;
      err       <= 1'b0;
      cls_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cls_q <= req_class;
            f3_q  <= req_funct3;
            rd_q  <= req_rd;
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            imm_q <= req_imm;
            state <= S_ENC;
          end
        end
        S_ENC: begin
          if (enc_ok) begin
            mem_wdata <= packed_word;
            mem_we    <= 1'b1;
            state     <= S_WR;
          end else begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_WR: begin
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_addr <= mem_addr + ADDRESS_WIDTH'(4);
            count    <= count + 16'd1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (clear) begin
        mem_addr <= BASE_ADDR;
        count    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; a second instance with a 4-bit
// address and base 0xC exercises address wrap-around.
module tb_instr_encoder;
  import instr_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        req_valid;
  logic        req_valid4;
  logic [2:0]  req_class;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        mem_ready;
  logic        mem_ready4;

  logic        req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] count;
  logic        err;

  logic        req_ready4;
  logic        mem_we4;
  logic [3:0]  mem_addr4;
  logic [31:0] mem_wdata4;
  logic [15:0] count4;
  logic        err4;

  int checks;
  int failures;

  logic [2:0]  v_cls [4];
  logic [2:0]  v_f3  [4];
  logic [4:0]  v_rd  [4];
  logic [4:0]  v_rs1 [4];
  logic [4:0]  v_rs2 [4];
  logic [31:0] v_imm [4];
  logic [31:0] v_exp [4];

  instr_encoder #(.ADDRESS_WIDTH(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_funct3(req_funct3), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .err(err)
  );

  instr_encoder #(.ADDRESS_WIDTH(4), .BASE_ADDR(4'hC)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_class(req_class), .req_funct3(req_funct3), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_ready(mem_ready4), .count(count4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge while the target instance is idle; returns at the ENC-cycle negedge.
  task automatic send(input bit sel4, input logic [2:0] cls, input logic [2:0] f3,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im);
    req_class = cls; req_funct3 = f3; req_rd = d; req_rs1 = s1; req_rs2 = s2; req_imm = im;
    if (sel4) req_valid4 = 1'b1; else req_valid = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
  endtask

  task automatic run_write(input bit sel4, input logic [2:0] cls, input logic [2:0] f3,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] im);
    send(sel4, cls, f3, d, s1, s2, im);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0;
    mem_ready = 1'b1; mem_ready4 = 1'b1;
    req_class = '0; req_funct3 = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    repeat (2) @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata got=%h exp=0", mem_wdata); end
    checks++; if (count !== 16'h0) begin failures++; $display("[TB] FAIL reset_count got=%h exp=0", count); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    checks++; if (mem_addr4 !== 4'hC) begin failures++; $display("[TB] FAIL reset_addr4 got=%h exp=c", mem_addr4); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_alui();
    send(1'b0, CLS_ALUI, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL alui_we_enc got=%b exp=0", mem_we); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL alui_we_wr got=%b exp=1", mem_we); end
    checks++; if (mem_wdata !== 32'h00500093) begin failures++; $display("[TB] FAIL alui_wdata got=%h exp=00500093", mem_wdata); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL alui_addr got=%h exp=0", mem_addr); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL alui_ready_wr got=%b exp=0", req_ready); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL alui_we_done got=%b exp=0", mem_we); end
    checks++; if (count !== 16'd1) begin failures++; $display("[TB] FAIL alui_count got=%0d exp=1", count); end
    checks++; if (mem_addr !== 32'h4) begin failures++; $display("[TB] FAIL alui_next_addr got=%h exp=4", mem_addr); end
  endtask

  task automatic test_branch_store();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL clear_addr got=%h exp=0", mem_addr); end
    checks++; if (count !== 16'd0) begin failures++; $display("[TB] FAIL clear_count got=%0d exp=0", count); end
    run_write(1'b0, CLS_BRANCH, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8);
    checks++; if (mem_wdata !== 32'h00208463) begin failures++; $display("[TB] FAIL branch_wdata got=%h exp=00208463", mem_wdata); end
    @(negedge clk);
    run_write(1'b0, CLS_STORE, 3'b010, 5'd0, 5'd1, 5'd2, 32'd4);
    checks++; if (mem_wdata !== 32'h0020A223) begin failures++; $display("[TB] FAIL store_wdata got=%h exp=0020a223", mem_wdata); end
    checks++; if (mem_addr !== 32'h4) begin failures++; $display("[TB] FAIL store_addr got=%h exp=4", mem_addr); end
    @(negedge clk);
    checks++; if (count !== 16'd2) begin failures++; $display("[TB] FAIL store_count got=%0d exp=2", count); end
  endtask

  task automatic test_jal_lui();
    run_write(1'b0, CLS_JAL, 3'b000, 5'd1, 5'd0, 5'd0, 32'd16);
    checks++; if (mem_wdata !== 32'h010000EF) begin failures++; $display("[TB] FAIL jal_wdata got=%h exp=010000ef", mem_wdata); end
    @(negedge clk);
    run_write(1'b0, CLS_LUI, 3'b000, 5'd5, 5'd0, 5'd0, 32'h12345000);
    checks++; if (mem_wdata !== 32'h123452B7) begin failures++; $display("[TB] FAIL lui_wdata got=%h exp=123452b7", mem_wdata); end
    checks++; if (mem_addr !== 32'hC) begin failures++; $display("[TB] FAIL lui_addr got=%h exp=c", mem_addr); end
    @(negedge clk);
    checks++; if (count !== 16'd4) begin failures++; $display("[TB] FAIL lui_count got=%0d exp=4", count); end
  endtask

  task automatic test_other_classes();
    v_cls = '{CLS_ALUI, CLS_LOAD, CLS_JALR, CLS_BRANCH};
    v_f3  = '{3'd1, 3'd2, 3'd0, 3'd1};
    v_rd  = '{5'd3, 5'd6, 5'd0, 5'd0};
    v_rs1 = '{5'd3, 5'd2, 5'd1, 5'd5};
    v_rs2 = '{5'd0, 5'd0, 5'd0, 5'd6};
    v_imm = '{32'd7, 32'hFFFFFFFC, 32'd0, 32'hFFFFFFF8};
    v_exp = '{32'h00719193, 32'hFFC12303, 32'h00008067, 32'hFE629CE3};
    for (int i = 0; i < 4; i++) begin
      run_write(1'b0, v_cls[i], v_f3[i], v_rd[i], v_rs1[i], v_rs2[i], v_imm[i]);
      checks++; if (mem_wdata !== v_exp[i]) begin failures++; $display("[TB] FAIL vec%0d_wdata got=%h exp=%h", i, mem_wdata, v_exp[i]); end
      checks++; if (mem_addr !== 32'h10 + 32'(4 * i)) begin failures++; $display("[TB] FAIL vec%0d_addr got=%h exp=%h", i, mem_addr, 32'h10 + 32'(4 * i)); end
      @(negedge clk);
    end
    checks++; if (count !== 16'd8) begin failures++; $display("[TB] FAIL vec_count got=%0d exp=8", count); end
  endtask

  task automatic test_stall();
    mem_ready = 1'b0;
    run_write(1'b0, CLS_ALUI, 3'b000, 5'd2, 5'd0, 5'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL stall%0d_we got=%b exp=1", i, mem_we); end
      checks++; if (mem_addr !== 32'h20) begin failures++; $display("[TB] FAIL stall%0d_addr got=%h exp=20", i, mem_addr); end
      checks++; if (mem_wdata !== 32'h00100113) begin failures++; $display("[TB] FAIL stall%0d_wdata got=%h exp=00100113", i, mem_wdata); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall%0d_ready got=%b exp=0", i, req_ready); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL stall_we_4th got=%b exp=1", mem_we); end
    checks++; if (count !== 16'd8) begin failures++; $display("[TB] FAIL stall_count_4th got=%0d exp=8", count); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL stall_we_done got=%b exp=0", mem_we); end
    checks++; if (count !== 16'd9) begin failures++; $display("[TB] FAIL stall_count_done got=%0d exp=9", count); end
    checks++; if (mem_addr !== 32'h24) begin failures++; $display("[TB] FAIL stall_addr_done got=%h exp=24", mem_addr); end
  endtask

  task automatic test_clear_collision();
    run_write(1'b0, CLS_LUI, 3'b000, 5'd1, 5'd0, 5'd0, 32'hABCDE000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL clrcol_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL clrcol_addr got=%h exp=0", mem_addr); end
    checks++; if (count !== 16'd0) begin failures++; $display("[TB] FAIL clrcol_count got=%0d exp=0", count); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL clrcol_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_wrap();
    run_write(1'b1, CLS_ALUI, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
    checks++; if (mem_we4 !== 1'b1) begin failures++; $display("[TB] FAIL wrap1_we got=%b exp=1", mem_we4); end
    checks++; if (mem_addr4 !== 4'hC) begin failures++; $display("[TB] FAIL wrap1_addr got=%h exp=c", mem_addr4); end
    checks++; if (mem_wdata4 !== 32'h00500093) begin failures++; $display("[TB] FAIL wrap1_wdata got=%h exp=00500093", mem_wdata4); end
    @(negedge clk);
    run_write(1'b1, CLS_JAL, 3'b000, 5'd1, 5'd0, 5'd0, 32'd16);
    checks++; if (mem_addr4 !== 4'h0) begin failures++; $display("[TB] FAIL wrap2_addr got=%h exp=0", mem_addr4); end
    @(negedge clk);
    checks++; if (count4 !== 16'd2) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=2", count4); end
    checks++; if (mem_addr4 !== 4'h4) begin failures++; $display("[TB] FAIL wrap_next_addr got=%h exp=4", mem_addr4); end
    checks++; if (count !== 16'd0) begin failures++; $display("[TB] FAIL wrap_main_idle got=%0d exp=0", count); end
  endtask

  task automatic test_reset_in_wr();
    mem_ready = 1'b0;
    run_write(1'b0, CLS_ALUI, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL rstwr_we_before got=%b exp=1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rstwr_we got=%b exp=0", mem_we); end
    checks++; if (count !== 16'd0) begin failures++; $display("[TB] FAIL rstwr_count got=%0d exp=0", count); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rstwr_addr got=%h exp=0", mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstwr_ready got=%b exp=1", req_ready); end
    repeat (3) @(negedge clk);
    checks++; if (count !== 16'd0) begin failures++; $display("[TB] FAIL rstwr_no_write got=%0d exp=0", count); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rstwr_we_after got=%b exp=0", mem_we); end
  endtask

`ifdef INSTR_ENC_CHECK_EN
  task automatic test_illegal();
    send(1'b0, CLS_LOAD, 3'b000, 5'd1, 5'd2, 5'd0, 32'd0);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL ill_err_enc got=%b exp=0", err); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL ill_err got=%b exp=1", err); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL ill_we got=%b exp=0", mem_we); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL ill_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL ill_err_pulse got=%b exp=0", err); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL ill_addr got=%h exp=0", mem_addr); end
    checks++; if (count !== 16'd0) begin failures++; $display("[TB] FAIL ill_count got=%0d exp=0", count); end
    send(1'b0, 3'd7, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL ill_unknown_err got=%b exp=1", err); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL ill_unknown_we got=%b exp=0", mem_we); end
    @(negedge clk);
  endtask
`else
  task automatic test_illegal();
    run_write(1'b0, 3'd7, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0);
    checks++; if (mem_wdata !== 32'h00000013) begin failures++; $display("[TB] FAIL nop_wdata got=%h exp=00000013", mem_wdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL nop_err got=%b exp=0", err); end
    @(negedge clk);
    run_write(1'b0, CLS_LOAD, 3'b000, 5'd1, 5'd2, 5'd0, 32'd0);
    checks++; if (mem_wdata !== 32'h00010083) begin failures++; $display("[TB] FAIL lb_wdata got=%h exp=00010083", mem_wdata); end
    checks++; if (mem_addr !== 32'h4) begin failures++; $display("[TB] FAIL lb_addr got=%h exp=4", mem_addr); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL lb_err got=%b exp=0", err); end
    @(negedge clk);
    checks++; if (count !== 16'd2) begin failures++; $display("[TB] FAIL lb_count got=%0d exp=2", count); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    $display("[TB] starting instr_encoder bench");
    test_reset();
    test_alui();
    test_branch_store();
    test_jal_lui();
    test_other_classes();
    test_stall();
    test_clear_collision();
    test_wrap();
    test_reset_in_wr();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
